game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game controller for Unicorn Explosion. It owns the game state machine (idle, run, dying, over) and synchronises and debounces the jump button. It latches the speed and difficulty selections at game start and generates the single-cycle game tick enable that paces the physics, map and score engines. Sits between the board inputs and the engine modules; all outputs are in the CLK100MHZ domain.

## Interface
- ACC_W, 27, tick accumulator width; tick period = 2^ACC_W / speed cycles
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a button change (10 ms)
- DEATH_HOLD_TICKS, 8, internal ticks spent in DYING before OVER
- CLK100MHZ  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous, active-low reset
- jump_btn  in  1  raw centre button, asynchronous
- speed_in  in  4  speed switches (priority encoded)
- difficulty_in  in  4  difficulty switches (priority encoded)
- isdead  in  1  death flag from physics engine, level
- start  out  1  game active (RUN, DYING or OVER)
- game_tick  out  1  one-cycle enable, RUN only
- jump  out  1  debounced button level
- jump_rise  out  1  one-cycle pulse on debounced rising edge
- speed  out  4  latched speed code
- difficulty  out  2  latched difficulty
- state  out  2  IDLE=0, RUN=1, DYING=2, OVER=3

## Operation
- Reset values: state=IDLE, start=0, game_tick=0, jump=0, jump_rise=0, speed=3, difficulty=0, accumulator=0, hold counter=0.
- Button path: 2-flop synchroniser, then debounce, then edge detect. jump_rise = jump & ~jump_q.
- Speed encoding: speed_in[3]→9, [2]→7, [1]→6, [0]→4, none→3.
- Difficulty encoding: difficulty_in[3]→3, [2]→2, [1]→1, else 0.
- IDLE: accumulator held at 0. On jump_rise, latch speed and difficulty from the switches, clear the accumulator and go to RUN.
- RUN: each cycle acc ← acc + speed, computed at ACC_W+1 bits. game_tick = carry out of bit ACC_W-1. On isdead=1, go to DYING and clear the hold counter.
- DYING: the accumulator keeps running and game_tick is forced 0. Each carry increments the hold counter. When the count reaches DEATH_HOLD_TICKS, go to OVER. jump_rise is ignored.
- OVER: accumulator frozen. On jump_rise, go to IDLE; start deasserts so the map and score engines reinitialise.
- Priority: reset_n low beats everything. In RUN, isdead beats jump_rise in the same cycle.
- Switch changes during RUN, DYING or OVER have no effect until the next IDLE→RUN.
- Accumulator wrap is modulo 2^ACC_W. No overflow handling is needed because only the carry is consumed.

## Timing
- jump_btn to jump: 2 synchroniser cycles + DEBOUNCE_CYCLES + 1 register cycle.
- jump_rise is asserted on the cycle after jump rises, for exactly 1 cycle.
- jump_rise to state=RUN and start=1: 1 cycle, registered.
- First game_tick arrives exactly ceil(2^ACC_W / speed) cycles after entering RUN.
- isdead to state=DYING: 1 cycle. game_tick is 0 from that cycle onward.
- All outputs are registered. None are combinational from inputs.
- reset_n assertion clears all state immediately. Deassertion takes effect on the next clock edge, and the surrounding logic must synchronise the deassertion.

## Configuration
- GAME_SEQ_DEBOUNCE_EN defined: the counter debouncer is present, and jump follows the synchronised button only after DEBOUNCE_CYCLES stable samples.
- Not defined: jump = synchronised button directly, with 2-cycle latency. DEBOUNCE_CYCLES is unused. Intended for simulation and for boards with hardware-debounced buttons.

## Structure
- game_pkg holds:
  - the state encoding constants IDLE, RUN, DYING, OVER
  - the speed codes 3/4/6/7/9
  - the speed and difficulty encode functions, which the display and score engines also use
- Sub-module btn_debounce (synchroniser + stability counter + edge detect), instantiated once. The macro selects its counter path.
- The state machine, accumulator and hold counter live in game_sequencer.

## Test plan
Benches use ACC_W=8, DEBOUNCE_CYCLES=4, DEATH_HOLD_TICKS=2, macro defined.
- Reset: hold reset_n=0 with jump_btn=1 → state=0, start=0, speed=3, no jump_rise.
- Start: speed_in=4'b0101, difficulty_in=4'b0010, press jump 10 cycles → one jump_rise; next cycle state=1, start=1, speed=7, difficulty=1.
- Tick pacing in RUN at speed 7 → first game_tick 37 cycles after entry. Ticks are one cycle wide, and the average spacing is 256/7 cycles.
- Bounce: toggle jump_btn every 2 cycles for 20 cycles → jump stays 0 and no jump_rise.
- Death: assert isdead together with jump_rise in RUN → state=2 next cycle, game_tick=0. After 2 internal carries, state=3. A jump press in DYING is ignored.
- Restart: in OVER, change speed_in to 4'b1000 and press jump → state=0, start=0. The next press gives RUN with speed=9.

Source files
------------

// File: rtl/game_pkg.sv
// Shared Unicorn Explosion game definitions: state encoding, speed codes and
// the switch encoders also used by the display and score engines.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam logic [3:0] SPEED_NONE = 4'd3;
  localparam logic [3:0] SPEED_SW0  = 4'd4;
  localparam logic [3:0] SPEED_SW1  = 4'd6;
  localparam logic [3:0] SPEED_SW2  = 4'd7;
  localparam logic [3:0] SPEED_SW3  = 4'd9;

  function automatic logic [3:0] encode_speed(input logic [3:0] sw);
    casez (sw)
      4'b1???: return SPEED_SW3;
      4'b01??: return SPEED_SW2;
      4'b001?: return SPEED_SW1;
      4'b0001: return SPEED_SW0;
      default: return SPEED_NONE;
    endcase
  endfunction

  function automatic logic [1:0] encode_difficulty(input logic [3:0] sw);
    casez (sw)
      4'b1???: return 2'd3;
      4'b01??: return 2'd2;
      4'b001?: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Jump button conditioning: 2-flop synchroniser, stability counter, rising-edge pulse.
// GAME_SEQ_DEBOUNCE_EN enables the counter; otherwise level is the synchronised button.
module btn_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK100MHZ,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic sync_1, sync_2, level_q;

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

`ifdef GAME_SEQ_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Down-counter runs only while the synchronised input disagrees with level.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      level <= 1'b0;
      cnt   <= CNT_RELOAD;
    end else if (sync_2 == level) begin
      cnt <= CNT_RELOAD;
    end else if (cnt == '0) begin
      level <= sync_2;
      cnt   <= CNT_RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign level = sync_2;
`endif

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Unicorn Explosion game controller: game FSM, speed/difficulty latch and tick pacing.
// Build option GAME_SEQ_DEBOUNCE_EN selects the counter debouncer in btn_debounce.
//
// state | meaning
// IDLE  | waiting for a jump press, accumulator held at 0
// RUN   | game running, game_tick paced by the accumulator carry
// DYING | death animation, carries counted, ticks suppressed
// OVER  | accumulator frozen, jump press returns to IDLE
module game_sequencer
  import game_pkg::*;
#(
  parameter int ACC_W            = 27,
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int DEATH_HOLD_TICKS = 8
) (
  input  logic       CLK100MHZ,
  input  logic       reset_n,
  input  logic       jump_btn,
  input  logic [3:0] speed_in,
  input  logic [3:0] difficulty_in,
  input  logic       isdead,
  output logic       start,
  output logic       game_tick,
  output logic       jump,
  output logic       jump_rise,
  output logic [3:0] speed,
  output logic [1:0] difficulty,
  output logic [1:0] state
);

  localparam int HOLD_W = $clog2(DEATH_HOLD_TICKS + 1);

  game_state_t       state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W:0]    acc_sum;
  logic              carry;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        speed_d;
  logic [1:0]        difficulty_d;
  logic              tick_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .CLK100MHZ(CLK100MHZ),
    .reset_n  (reset_n),
    .btn      (jump_btn),
    .level    (jump),
    .rise     (jump_rise)
  );

  // Only the carry out of the top bit is consumed, so the wrap is harmless.
  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(speed);
  assign carry   = acc_sum[ACC_W];

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    hold_d       = hold_q;
    speed_d      = speed;
    difficulty_d = difficulty;
    tick_d       = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (jump_rise) begin
          speed_d      = encode_speed(speed_in);
          difficulty_d = encode_difficulty(difficulty_in);
          state_d      = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum[ACC_W-1:0];
        if (isdead) begin
          state_d = DYING;
          hold_d  = '0;
        end else begin
          tick_d = carry;
        end
      end
      DYING: begin
        acc_d = acc_sum[ACC_W-1:0];
        if (carry) hold_d = hold_q + 1'b1;
        if (hold_d == HOLD_W'(DEATH_HOLD_TICKS)) state_d = OVER;
      end
      OVER: begin
        if (jump_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      hold_q     <= '0;
      speed      <= SPEED_NONE;
      difficulty <= 2'd0;
      game_tick  <= 1'b0;
      start      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      hold_q     <= hold_d;
      speed      <= speed_d;
      difficulty <= difficulty_d;
      game_tick  <= tick_d;
      start      <= (state_d != IDLE);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: behavioural model compared every cycle, plus
// directed presses, bounce, death and restart scenarios with literal expectations.
`timescale 1ns/1ps
module tb_game_sequencer;

  localparam int ACC_W            = 8;
  localparam int DEBOUNCE_CYCLES  = 4;
  localparam int DEATH_HOLD_TICKS = 2;

  logic       CLK100MHZ = 1'b0;
  logic       reset_n, jump_btn, isdead;
  logic [3:0] speed_in, difficulty_in;
  logic       start, game_tick, jump, jump_rise;
  logic [3:0] speed;
  logic [1:0] difficulty, state;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  game_sequencer #(
    .ACC_W           (ACC_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DEATH_HOLD_TICKS(DEATH_HOLD_TICKS)
  ) dut (
    .CLK100MHZ    (CLK100MHZ),
    .reset_n      (reset_n),
    .jump_btn     (jump_btn),
    .speed_in     (speed_in),
    .difficulty_in(difficulty_in),
    .isdead       (isdead),
    .start        (start),
    .game_tick    (game_tick),
    .jump         (jump),
    .jump_rise    (jump_rise),
    .speed        (speed),
    .difficulty   (difficulty),
    .state        (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic   hist[$];
  int     m_jump, m_jq, m_rise, m_state, m_speed, m_diff, m_tick, m_start;
  longint m_n, m_base;

  function automatic int enc_speed(input logic [3:0] sw);
    if (sw[3]) return 9;
    if (sw[2]) return 7;
    if (sw[1]) return 6;
    if (sw[0]) return 4;
    return 3;
  endfunction

  function automatic int enc_diff(input logic [3:0] sw);
    if (sw[3]) return 3;
    if (sw[2]) return 2;
    if (sw[1]) return 1;
    return 0;
  endfunction

  // Ticks owed after n accumulator updates at speed s.
  function automatic longint carries(input longint n, input int s);
    return (n * s) >> ACC_W;
  endfunction

  initial forever begin : model
    int   jump_prev, rise_prev;
    logic same;
    @(posedge CLK100MHZ or negedge reset_n);
    if (!reset_n) begin
      hist.delete();
      for (int i = 0; i < 2 + DEBOUNCE_CYCLES; i++) hist.push_back(1'b0);
      m_jump = 0; m_jq = 0; m_rise = 0; m_state = 0; m_speed = 3; m_diff = 0;
      m_tick = 0; m_start = 0; m_n = 0; m_base = 0;
    end else begin
      jump_prev = m_jump;
      rise_prev = m_rise;
      hist.push_front(jump_btn);
      void'(hist.pop_back());
`ifdef GAME_SEQ_DEBOUNCE_EN
      same = 1'b1;
      for (int i = 3; i < 2 + DEBOUNCE_CYCLES; i++) if (hist[i] != hist[2]) same = 1'b0;
      if (same && (int'(hist[2]) != m_jump)) m_jump = int'(hist[2]);
`else
      m_jump = int'(hist[1]);
`endif
      m_rise = (jump_prev == 1 && m_jq == 0) ? 1 : 0;
      m_jq   = jump_prev;
      m_tick = 0;
      case (m_state)
        0: if (rise_prev != 0) begin
          m_speed = enc_speed(speed_in);
          m_diff  = enc_diff(difficulty_in);
          m_state = 1;
          m_n     = 0;
        end
        1: begin
          m_n++;
          if (isdead) begin
            m_state = 2;
            m_base  = carries(m_n, m_speed);
          end else begin
            m_tick = int'(carries(m_n, m_speed) - carries(m_n - 1, m_speed));
          end
        end
        2: begin
          m_n++;
          if (carries(m_n, m_speed) - m_base >= DEATH_HOLD_TICKS) m_state = 3;
        end
        default: if (rise_prev != 0) m_state = 0;
      endcase
      m_start = (m_state != 0) ? 1 : 0;
    end
  end

  initial forever begin
    @(posedge CLK100MHZ);
    cycle++;
  end

  initial forever begin
    @(negedge CLK100MHZ);
    chk("cmp_state", state, m_state);
    chk("cmp_start", start, m_start);
    chk("cmp_game_tick", game_tick, m_tick);
    chk("cmp_jump", jump, m_jump);
    chk("cmp_jump_rise", jump_rise, m_rise);
    chk("cmp_speed", speed, m_speed);
    chk("cmp_difficulty", difficulty, m_diff);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_state(input string name, input logic [1:0] st, input int budget);
    int n;
    n = 0;
    while (state !== st && n < budget) begin
      @(negedge CLK100MHZ);
      n++;
    end
    chk(name, state, st);
  endtask

  task automatic wait_rise(input string name, input int budget);
    int n;
    n = 0;
    while (jump_rise !== 1'b1 && n < budget) begin
      @(negedge CLK100MHZ);
      n++;
    end
    chk(name, jump_rise, 1);
  endtask

  task automatic wait_tick(input int budget);
    int n;
    n = 0;
    while (game_tick !== 1'b1 && n < budget) begin
      @(negedge CLK100MHZ);
      n++;
    end
  endtask

  initial begin
    int t_entry, t1, rises, highs, ticks, n;
    reset_n = 1'b0; jump_btn = 1'b1; isdead = 1'b0;
    speed_in = 4'b0000; difficulty_in = 4'b0000;
    repeat (4) @(negedge CLK100MHZ);
    chk("rst_state", state, 0);
    chk("rst_start", start, 0);
    chk("rst_speed", speed, 3);
    chk("rst_difficulty", difficulty, 0);
    chk("rst_jump_rise", jump_rise, 0);
    chk("rst_game_tick", game_tick, 0);
    jump_btn = 1'b0;
    @(negedge CLK100MHZ);
    reset_n = 1'b1;
    repeat (10) @(negedge CLK100MHZ);
    chk("idle_after_reset", state, 0);

    // Start: one press, speed 7, difficulty 1
    speed_in = 4'b0101; difficulty_in = 4'b0010; jump_btn = 1'b1;
    rises = 0; t_entry = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK100MHZ);
      rises += int'(jump_rise);
      if (state == 2'd1 && t_entry < 0) t_entry = cycle;
    end
    jump_btn = 1'b0;
    chk("start_one_rise", rises, 1);
    chk("start_entry_seen", (t_entry >= 0) ? 1 : 0, 1);
    chk("start_state", state, 1);
    chk("start_start", start, 1);
    chk("start_speed", speed, 7);
    chk("start_difficulty", difficulty, 1);
    chk("model_speed", m_speed, 7);
    chk("model_state", m_state, 1);

    // Tick pacing; switch change in RUN must not matter
    speed_in = 4'b1000;
    wait_tick(100);
    t1 = cycle;
    chk("first_tick_latency", t1 - t_entry, 37);
    @(negedge CLK100MHZ);
    chk("tick_one_cycle", game_tick, 0);
    ticks = 0; n = 0;
    while (ticks < 7 && n < 400) begin
      @(negedge CLK100MHZ);
      n++;
      if (game_tick) ticks++;
    end
    chk("seven_ticks_256_cycles", cycle - t1, 256);
    chk("run_speed_held", speed, 7);

    // Bounce: 2-cycle toggles for 20 cycles
    rises = 0; highs = 0;
    for (int i = 0; i < 30; i++) begin
      jump_btn = (i < 20) && ((i / 2) % 2 == 0);
      @(negedge CLK100MHZ);
      rises += int'(jump_rise);
      highs += int'(jump);
    end
`ifdef GAME_SEQ_DEBOUNCE_EN
    chk("bounce_jump_low", highs, 0);
    chk("bounce_no_rise", rises, 0);
`endif
    chk("bounce_still_run", state, 1);

    // Death together with jump_rise
    jump_btn = 1'b1;
    wait_rise("death_rise_seen", 30);
    isdead = 1'b1;
    @(negedge CLK100MHZ);
    isdead = 1'b0; jump_btn = 1'b0;
    chk("dying_state", state, 2);
    chk("dying_no_tick", game_tick, 0);
    repeat (8) @(negedge CLK100MHZ);
    jump_btn = 1'b1;
    wait_rise("dying_press_rise", 30);
    @(negedge CLK100MHZ);
    chk("dying_ignores_jump", state, 2);
    jump_btn = 1'b0;
    wait_state("over_reached", 2'd3, 200);

    // Restart with new switches
    speed_in = 4'b1000; difficulty_in = 4'b1100;
    repeat (10) @(negedge CLK100MHZ);
    jump_btn = 1'b1;
    wait_state("restart_idle", 2'd0, 30);
    chk("restart_start_low", start, 0);
    jump_btn = 1'b0;
    repeat (10) @(negedge CLK100MHZ);
    chk("idle_holds", state, 0);
    jump_btn = 1'b1;
    wait_state("rerun", 2'd1, 30);
    t_entry = cycle;
    chk("rerun_speed", speed, 9);
    chk("rerun_difficulty", difficulty, 3);
    chk("rerun_start", start, 1);
    jump_btn = 1'b0;
    wait_tick(100);
    chk("speed9_first_tick", cycle - t_entry, 29);

    // Asynchronous reset mid-run
    @(negedge CLK100MHZ);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_start", start, 0);
    chk("async_rst_speed", speed, 3);
    repeat (2) @(negedge CLK100MHZ);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
